timer_alarm_bank: RTL and testbench
===================================

Name: timer_alarm_bank

Overview:
Parametrised multi-field alarm/timer register bank. It stores N_FIELDS time fields of DATA_W bits each, for example seconds, minutes and hours. Each field is loadable from either the RTC data bus or the live counter, and the whole set is continuously compared against the live count. An arm/ring/disarm state machine owns the alarm flag, and a video mux selects live count or stored set-point for the VGA overlay.

Parameters:
N_FIELDS, 3, number of time fields in the bank
DATA_W, 8, width of each field (BCD byte by default)
SEL_W, 2, width of field_sel; must satisfy 2^SEL_W >= N_FIELDS
RING_CYCLES, 1000000, auto-silence timeout in clk cycles (used only with the optional feature)

Ports:
clk  in  1  system clock, all logic on rising edge
reset  in  1  synchronous, active-high; one clock, sampled on rising edge of clk
hold  in  1  1 = freeze stored fields; writes ignored
chip_select  in  1  write source: 0 = in_rtc_dato, 1 = selected field of in_count_dato
wr_en  in  1  single-cycle write strobe
field_sel  in  SEL_W  index of field to write
in_rtc_dato  in  DATA_W  data from RTC interface
in_count_dato  in  N_FIELDS*DATA_W  live count; field i at bits [i*DATA_W +: DATA_W]
arm  in  1  pulse: arm the alarm
btn_desactivar  in  1  debounced level: disarm / silence
estado_alarma  in  1  VGA source select: 1 = live count, 0 = stored fields
out_dato_vga  out  N_FIELDS*DATA_W  display data
flag_out  out  1  1 while ringing
armed  out  1  1 while in ARMED
match  out  1  combinational: all stored fields equal live count

Behaviour:
- Reset (synchronous): all stored fields = 0, state = IDLE, match_prev = 0, flag_out = 0, armed = 0.
- Field write occurs at the rising edge where wr_en=1, hold=0 and field_sel < N_FIELDS.
  - Target field = chip_select ? in_count_dato[field_sel] : in_rtc_dato.
  - Other fields are unchanged.
  - field_sel >= N_FIELDS: write silently dropped.
  - hold=1 overrides wr_en.
- Written value is visible on out_dato_vga (when estado_alarma=0) the cycle after the write edge.
- match = AND over i of (stored[i] == count[i]); purely combinational.
- match_prev is registered every cycle; match_rise = match & ~match_prev.
- FSM states IDLE, ARMED, RINGING:
  - IDLE -> ARMED: arm=1.
  - ARMED -> RINGING: match_rise=1 and btn_desactivar=0.
  - ARMED -> IDLE: btn_desactivar=1; this wins over a simultaneous match_rise.
  - RINGING -> IDLE: btn_desactivar=1.
  - arm in ARMED or RINGING: ignored.
  - arm and btn_desactivar in the same cycle from IDLE: stay IDLE.
- flag_out = (state==RINGING) and armed = (state==ARMED); both are registered state decodes.
  - Latency: flag_out rises 1 clock after the edge at which count first equals the set-point.
- Arming while match is already 1 does not ring; ringing requires a new 0->1 transition of match.
- Writes remain legal in any state. A write that makes match rise while ARMED triggers ringing.
- out_dato_vga = estado_alarma ? in_count_dato : stored fields. Combinational mux, no added latency.
- Reset asserted mid-ring returns the block to IDLE with flag_out=0 on the next edge.

Optional Feature:
- Macro: TIMER_ALARM_AUTOSILENCE_EN.
- Defined:
  - A ring counter of ceil(log2(RING_CYCLES+1)) bits clears on RINGING entry and counts every cycle in RINGING.
  - When the count reaches RING_CYCLES-1, the FSM goes to IDLE on the next edge, so flag_out is high for exactly RING_CYCLES cycles.
  - btn_desactivar still exits RINGING immediately.
  - The counter is reset to 0 by reset.
- Undefined: no counter is built; RINGING is left only by btn_desactivar or reset.

Test Plan:
- Reset, then write 8'h30/8'h45/8'h12 from the RTC source to fields 0/1/2 with estado_alarma=0 -> out_dato_vga = 24'h124530 one cycle after the last write; flag_out = 0.
- hold=1 with wr_en=1, field_sel=0, in_rtc_dato=8'h99 -> field 0 stays 8'h30. field_sel=3 with N_FIELDS=3 -> no field changes.
- Arm, then step in_count_dato from 24'h124529 to 24'h124530 -> match rises, armed drops, and flag_out = 1 one clock later. Pulse btn_desactivar -> flag_out = 0 on the next edge.
- Count already equals the set-point, then pulse arm -> no ring. Count moves away and returns -> flag_out = 1.
- In ARMED, btn_desactivar=1 in the same cycle as match_rise -> state IDLE, flag_out stays 0.
- With TIMER_ALARM_AUTOSILENCE_EN and RING_CYCLES=5, trigger the alarm -> flag_out high for exactly 5 cycles, then IDLE. Assert reset on ring cycle 2 -> flag_out = 0 on the next edge.

Source files
------------

// File: rtl/timer_alarm_bank.sv
// timer_alarm_bank: bank of N_FIELDS stored time fields compared against a live
// count, with an arm/ring/disarm state machine and a display source mux.
// Optional build macro: TIMER_ALARM_AUTOSILENCE_EN (ringing stops by itself
// after RING_CYCLES clock cycles).
module timer_alarm_bank #(
    parameter int N_FIELDS    = 3,
    parameter int DATA_W      = 8,
    parameter int SEL_W       = 2,
    parameter int RING_CYCLES = 1000000
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         hold,
    input  logic                         chip_select,
    input  logic                         wr_en,
    input  logic [SEL_W-1:0]             field_sel,
    input  logic [DATA_W-1:0]            in_rtc_dato,
    input  logic [N_FIELDS*DATA_W-1:0]   in_count_dato,
    input  logic                         arm,
    input  logic                         btn_desactivar,
    input  logic                         estado_alarma,
    output logic [N_FIELDS*DATA_W-1:0]   out_dato_vga,
    output logic                         flag_out,
    output logic                         armed,
    output logic                         match
);

    localparam logic [1:0] ST_IDLE    = 2'd0;
    localparam logic [1:0] ST_ARMED   = 2'd1;
    localparam logic [1:0] ST_RINGING = 2'd2;

    logic [DATA_W-1:0]   field_q [N_FIELDS];
    logic [DATA_W-1:0]   field_d [N_FIELDS];
    logic [N_FIELDS-1:0] wr_hit;
    logic [N_FIELDS-1:0] match_vec;
    logic [N_FIELDS*DATA_W-1:0] stored_flat;

    logic       match_prev_q;
    logic       match_prev_d;
    logic       match_rise;
    logic [1:0] state_q;
    logic [1:0] state_d;
    logic       ring_timeout;

    // Per-field write decode, compare and flattening. A field_sel value at or
    // beyond N_FIELDS matches no index, so such writes fall away naturally.
    genvar gi;
    generate
        for (gi = 0; gi < N_FIELDS; gi++) begin : g_field
            assign wr_hit[gi]    = wr_en & ~hold & (field_sel == SEL_W'(gi));
            assign match_vec[gi] = (field_q[gi] == in_count_dato[gi*DATA_W +: DATA_W]);
            assign stored_flat[gi*DATA_W +: DATA_W] = field_q[gi];
        end
    endgenerate

    // Next value of each stored field: selected source on a hit, else hold.
    always_comb begin
        for (int i = 0; i < N_FIELDS; i++) begin
            field_d[i] = field_q[i];
            if (wr_hit[i]) begin
                field_d[i] = chip_select ? in_count_dato[i*DATA_W +: DATA_W] : in_rtc_dato;
            end
        end
    end

    // Stored field registers.
    always_ff @(posedge clk) begin
        for (int i = 0; i < N_FIELDS; i++) begin
            if (reset) begin
                field_q[i] <= '0;
            end else begin
                field_q[i] <= field_d[i];
            end
        end
    end

    assign match        = &match_vec;
    assign match_prev_d = match;
    assign match_rise   = match & ~match_prev_q;

`ifdef TIMER_ALARM_AUTOSILENCE_EN
    localparam int RC_W = $clog2(RING_CYCLES + 1);
    localparam logic [RC_W-1:0] RING_LAST = RC_W'(RING_CYCLES - 1);

    logic [RC_W-1:0] ring_cnt_q;
    logic [RC_W-1:0] ring_cnt_d;

    // Ring counter: held at zero outside RINGING so it starts fresh on entry.
    always_comb begin
        ring_cnt_d = '0;
        if (state_q == ST_RINGING) begin
            ring_cnt_d = ring_cnt_q + 1'b1;
        end
    end

    // Ring counter register.
    always_ff @(posedge clk) begin
        if (reset) begin
            ring_cnt_q <= '0;
        end else begin
            ring_cnt_q <= ring_cnt_d;
        end
    end

    assign ring_timeout = (state_q == ST_RINGING) && (ring_cnt_q == RING_LAST);
`else
    assign ring_timeout = 1'b0;
`endif

    // Alarm state machine; disarm always wins over arm and over a new match.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (arm && !btn_desactivar) begin
                    state_d = ST_ARMED;
                end
            end
            ST_ARMED: begin
                if (btn_desactivar) begin
                    state_d = ST_IDLE;
                end else if (match_rise) begin
                    state_d = ST_RINGING;
                end
            end
            ST_RINGING: begin
                if (btn_desactivar || ring_timeout) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // State and match history registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= ST_IDLE;
            match_prev_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            match_prev_q <= match_prev_d;
        end
    end

    assign flag_out     = (state_q == ST_RINGING);
    assign armed        = (state_q == ST_ARMED);
    assign out_dato_vga = estado_alarma ? in_count_dato : stored_flat;

endmodule

// File: tb/tb_timer_alarm_bank.sv
// Testbench for timer_alarm_bank: directed scenarios followed by random
// traffic, checked by a scoreboard fed from a behavioural model.
module tb_timer_alarm_bank;

    localparam int NF = 3;
    localparam int DW = 8;
    localparam int RC = 5;

    logic            clk = 1'b0;
    logic            reset = 1'b1;
    logic            hold = 1'b0;
    logic            chip_select = 1'b0;
    logic            wr_en = 1'b0;
    logic [1:0]      field_sel = '0;
    logic [DW-1:0]   in_rtc_dato = '0;
    logic [NF*DW-1:0] in_count_dato = '0;
    logic            arm = 1'b0;
    logic            btn_desactivar = 1'b0;
    logic            estado_alarma = 1'b0;
    logic [NF*DW-1:0] out_dato_vga;
    logic            flag_out;
    logic            armed;
    logic            match;

    timer_alarm_bank #(
        .N_FIELDS(NF), .DATA_W(DW), .SEL_W(2), .RING_CYCLES(RC)
    ) dut (
        .clk(clk), .reset(reset), .hold(hold), .chip_select(chip_select),
        .wr_en(wr_en), .field_sel(field_sel), .in_rtc_dato(in_rtc_dato),
        .in_count_dato(in_count_dato), .arm(arm), .btn_desactivar(btn_desactivar),
        .estado_alarma(estado_alarma), .out_dato_vga(out_dato_vga),
        .flag_out(flag_out), .armed(armed), .match(match)
    );

    always #5 clk = ~clk;

    typedef struct {
        int               id;
        logic [NF*DW-1:0] vga;
        logic             flag;
        logic             armd;
        logic             mtch;
    } exp_t;

    exp_t sb[$];
    int n_checks = 0;
    int n_fail   = 0;
    int n_tx     = 0;

    // Behavioural model: alarm "mode" as text, fields as plain bytes.
    string    m_mode = "IDLE";
    bit [7:0] m_f [NF];
    bit       m_was_equal = 1'b0;
    int       m_ring_left = 0;

    function automatic bit model_equal(input logic [NF*DW-1:0] cnt);
        for (int i = 0; i < NF; i++)
            if (m_f[i] != cnt[i*DW +: DW]) return 1'b0;
        return 1'b1;
    endfunction

    function automatic logic [NF*DW-1:0] model_set();
        logic [NF*DW-1:0] v;
        for (int i = 0; i < NF; i++) v[i*DW +: DW] = m_f[i];
        return v;
    endfunction

    // One clock of stimulus: drive, record expectation, advance the model.
    task automatic step(input bit rst_i, input bit hold_i, input bit cs_i, input bit wr_i,
                        input logic [1:0] sel_i, input logic [7:0] rtc_i,
                        input logic [NF*DW-1:0] cnt_i, input bit arm_i, input bit btn_i,
                        input bit est_i);
        exp_t e;
        bit   eq;
        bit   newly_equal;
        @(posedge clk);
        #1;
        reset = rst_i; hold = hold_i; chip_select = cs_i; wr_en = wr_i;
        field_sel = sel_i; in_rtc_dato = rtc_i; in_count_dato = cnt_i;
        arm = arm_i; btn_desactivar = btn_i; estado_alarma = est_i;

        eq     = model_equal(cnt_i);
        e.id   = n_tx;
        e.vga  = est_i ? cnt_i : model_set();
        e.flag = (m_mode == "RINGING");
        e.armd = (m_mode == "ARMED");
        e.mtch = eq;
        sb.push_back(e);
        n_tx++;

        if (rst_i) begin
            for (int i = 0; i < NF; i++) m_f[i] = 8'h00;
            m_mode = "IDLE";
            m_was_equal = 1'b0;
            m_ring_left = 0;
        end else begin
            newly_equal = eq && !m_was_equal;
            m_was_equal = eq;
            if (m_mode == "IDLE") begin
                if (arm_i && !btn_i) m_mode = "ARMED";
            end else if (m_mode == "ARMED") begin
                if (btn_i) m_mode = "IDLE";
                else if (newly_equal) begin
                    m_mode = "RINGING";
                    m_ring_left = RC;
                end
            end else begin
                if (btn_i) m_mode = "IDLE";
`ifdef TIMER_ALARM_AUTOSILENCE_EN
                else begin
                    m_ring_left--;
                    if (m_ring_left == 0) m_mode = "IDLE";
                end
`endif
            end
            if (wr_i && !hold_i && sel_i < NF)
                m_f[sel_i] = cs_i ? cnt_i[sel_i*DW +: DW] : rtc_i;
        end
    endtask

    task automatic idle(input logic [NF*DW-1:0] cnt_i, input int n);
        for (int k = 0; k < n; k++) step(0, 0, 0, 0, 2'd0, 8'h00, cnt_i, 0, 0, 0);
    endtask

    // Monitor: pops one expectation per cycle and compares at the falling edge.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (sb.size() > 0) begin
                e = sb.pop_front();
                n_checks += 4;
                if (out_dato_vga !== e.vga) begin
                    n_fail++;
                    $display("FAIL vga tx=%0d got=%h want=%h", e.id, out_dato_vga, e.vga);
                end
                if (flag_out !== e.flag) begin
                    n_fail++;
                    $display("FAIL flag_out tx=%0d got=%b want=%b", e.id, flag_out, e.flag);
                end
                if (armed !== e.armd) begin
                    n_fail++;
                    $display("FAIL armed tx=%0d got=%b want=%b", e.id, armed, e.armd);
                end
                if (match !== e.mtch) begin
                    n_fail++;
                    $display("FAIL match tx=%0d got=%b want=%b", e.id, match, e.mtch);
                end
                $display("tx %0d vga=%h flag=%b armed=%b match=%b", e.id,
                         out_dato_vga, flag_out, armed, match);
            end
        end
    end

    // Stimulus: directed scenarios, then random traffic near the set-point.
    initial begin
        logic [NF*DW-1:0] cnt;
        int mode;
        step(1, 0, 0, 0, 2'd0, 8'h00, 24'h000000, 0, 0, 0);
        // Load 12:45:30 from the RTC bus.
        step(0, 0, 0, 1, 2'd0, 8'h30, 24'h000000, 0, 0, 0);
        step(0, 0, 0, 1, 2'd1, 8'h45, 24'h000000, 0, 0, 0);
        step(0, 0, 0, 1, 2'd2, 8'h12, 24'h000000, 0, 0, 0);
        idle(24'h000000, 1);
        // Held write and out-of-range index must not change anything.
        step(0, 1, 0, 1, 2'd0, 8'h99, 24'h000000, 0, 0, 0);
        step(0, 0, 0, 1, 2'd3, 8'h77, 24'h000000, 0, 0, 0);
        idle(24'h000000, 1);
        // Arm then step the count onto the set-point; disarm.
        step(0, 0, 0, 0, 2'd0, 8'h00, 24'h124529, 1, 0, 0);
        idle(24'h124529, 1);
        idle(24'h124530, 3);
        step(0, 0, 0, 0, 2'd0, 8'h00, 24'h124530, 0, 1, 0);
        idle(24'h124530, 2);
        // Arm while already matching: no ring until match re-rises.
        step(0, 0, 0, 0, 2'd0, 8'h00, 24'h124530, 1, 0, 0);
        idle(24'h124530, 2);
        idle(24'h124531, 2);
        idle(24'h124530, 3);
        step(0, 0, 0, 0, 2'd0, 8'h00, 24'h124530, 0, 1, 1);
        // Disarm in the same cycle as the match rise.
        step(0, 0, 0, 0, 2'd0, 8'h00, 24'h124529, 1, 0, 0);
        idle(24'h124529, 1);
        step(0, 0, 0, 0, 2'd0, 8'h00, 24'h124530, 0, 1, 0);
        idle(24'h124530, 2);
        // Long ring (autosilence if built), then ring interrupted by reset.
        idle(24'h124529, 1);
        step(0, 0, 0, 0, 2'd0, 8'h00, 24'h124529, 1, 0, 0);
        idle(24'h124530, RC + 4);
        step(0, 0, 0, 0, 2'd0, 8'h00, 24'h124530, 0, 1, 0);
        idle(24'h124529, 1);
        step(0, 0, 0, 0, 2'd0, 8'h00, 24'h124529, 1, 0, 0);
        idle(24'h124530, 2);
        step(1, 0, 0, 0, 2'd0, 8'h00, 24'h124530, 0, 0, 0);
        idle(24'h124530, 2);
        // Count-source write copies a live field.
        step(0, 0, 1, 1, 2'd1, 8'h00, 24'h125930, 0, 0, 0);
        idle(24'h125930, 1);

        for (int t = 0; t < 3000; t++) begin
            mode = $urandom_range(0, 3);
            cnt = model_set();
            if (mode == 1) cnt[$urandom_range(0, NF-1)*DW +: DW] ^= 8'h01;
            else if (mode == 2) cnt = 24'($urandom);
            step($urandom_range(0, 99) < 2, $urandom_range(0, 4) == 0, 1'($urandom),
                 $urandom_range(0, 3) == 0, 2'($urandom), 8'($urandom_range(0, 3)), cnt,
                 $urandom_range(0, 9) == 0, $urandom_range(0, 11) == 0, 1'($urandom));
        end

        for (int w = 0; w < 10 && sb.size() > 0; w++) @(posedge clk);
        n_checks++;
        if (sb.size() != 0) begin
            n_fail++;
            $display("FAIL drain pending=%0d want=0", sb.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
